// File: rtl/status_register_pkg.sv
// ============================================================================
// Module : status_register_pkg
// Brief  : Flag bit indices, condition codes and status width shared by the
//          flag register and the condition checker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package status_register_pkg;

    localparam int STATUS_W = 4;

    // Bit positions within the packed {Z,C,N,V} status vector
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

endpackage

`default_nettype wire

// File: rtl/flag_pending_pipe.sv
// ============================================================================
// Module : flag_pending_pipe
// Brief  : Tracks in-flight flag writers between decode and commit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module flag_pending_pipe #(
    parameter int P_DEPTH = 2
) (
    input  logic i_Clock,
    input  logic i_Reset_n,
    input  logic i_Stall,
    input  logic i_Flush,
    input  logic i_Issue,
    output logic o_Busy
);

    logic [P_DEPTH-1:0] r_pipe;

    // Flush takes precedence over stall so killed writers never block decode.
    generate
        if (P_DEPTH == 1) begin : g_single
            always_ff @(posedge i_Clock or negedge i_Reset_n) begin
                if (!i_Reset_n) begin
                    r_pipe <= '0;
                end else if (i_Flush) begin
                    r_pipe <= '0;
                end else if (!i_Stall) begin
                    r_pipe <= i_Issue;
                end
            end
        end else begin : g_multi
            always_ff @(posedge i_Clock or negedge i_Reset_n) begin
                if (!i_Reset_n) begin
                    r_pipe <= '0;
                end else if (i_Flush) begin
                    r_pipe <= '0;
                end else if (!i_Stall) begin
                    r_pipe <= {r_pipe[P_DEPTH-2:0], i_Issue};
                end
            end
        end
    endgenerate

    assign o_Busy = |r_pipe;

endmodule

`default_nettype wire

// File: rtl/status_register.sv
// ============================================================================
// Module : status_register
// Brief  : Architectural {Z,C,N,V} flags, saved copy and decode flag hazard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module status_register
    import status_register_pkg::*;
#(
    parameter int P_PENDING_DEPTH = 2
) (
    input  logic                i_Clock,
    input  logic                i_Reset_n,
    input  logic                i_Stall,
    input  logic                i_Flush,
    input  logic                i_Ex_Valid,
    input  logic                i_Ex_S,
    input  logic                i_Ex_Cond_Pass,
    input  logic [STATUS_W-1:0] i_Alu_Status,
    input  logic                i_Id_Valid,
    input  logic                i_Id_S,
    input  logic                i_Id_Uses_Flags,
    input  logic                i_Save,
    input  logic                i_Restore,
    output logic [STATUS_W-1:0] o_Status,
    output logic [STATUS_W-1:0] o_Saved_Status,
    output logic                o_Flag_Hazard
);

    logic [STATUS_W-1:0] r_status;
    logic [STATUS_W-1:0] r_saved;
    logic [STATUS_W-1:0] w_next_status;
    logic                w_update;
    logic                w_restore;
    logic                w_save;
    logic                w_issue;
    logic                w_busy;

    assign w_update  = i_Ex_Valid & i_Ex_S & i_Ex_Cond_Pass & ~i_Flush & ~i_Stall;
    // Exception return normally flushes, so flush must not block restore.
    assign w_restore = i_Restore & ~i_Stall;
    assign w_save    = i_Save & ~i_Restore & ~i_Stall;

    always_comb begin
        w_next_status = r_status;
        if (w_restore) begin
            w_next_status = r_saved;
        end else if (w_update) begin
            w_next_status = i_Alu_Status;
        end
    end

    // Saving the next value folds a same-cycle commit into the saved copy.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_status <= '0;
            r_saved  <= '0;
        end else begin
            r_status <= w_next_status;
            if (w_save) begin
                r_saved <= w_next_status;
            end
        end
    end

    // A stalled writer must not enter the pipe, otherwise it would block itself.
    assign w_issue = i_Id_Valid & i_Id_S & ~o_Flag_Hazard;

    flag_pending_pipe #(
        .P_DEPTH (P_PENDING_DEPTH)
    ) u_pending (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Stall   (i_Stall),
        .i_Flush   (i_Flush),
        .i_Issue   (w_issue),
        .o_Busy    (w_busy)
    );

    assign o_Flag_Hazard  = i_Id_Valid & i_Id_Uses_Flags & w_busy;
    assign o_Status       = r_status;
    assign o_Saved_Status = r_saved;

endmodule

`default_nettype wire

// File: tb/tb_status_register.sv
// ============================================================================
// Module : tb_status_register
// Brief  : Directed self-checking bench for status_register (depth 2).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_status_register;

    logic       i_Clock = 1'b0;
    logic       i_Reset_n;
    logic       i_Stall, i_Flush;
    logic       i_Ex_Valid, i_Ex_S, i_Ex_Cond_Pass;
    logic [3:0] i_Alu_Status;
    logic       i_Id_Valid, i_Id_S, i_Id_Uses_Flags;
    logic       i_Save, i_Restore;
    logic [3:0] o_Status, o_Saved_Status;
    logic       o_Flag_Hazard;

    int checks = 0;
    int errors = 0;

    status_register #(.P_PENDING_DEPTH(2)) dut (
        .i_Clock         (i_Clock),
        .i_Reset_n       (i_Reset_n),
        .i_Stall         (i_Stall),
        .i_Flush         (i_Flush),
        .i_Ex_Valid      (i_Ex_Valid),
        .i_Ex_S          (i_Ex_S),
        .i_Ex_Cond_Pass  (i_Ex_Cond_Pass),
        .i_Alu_Status    (i_Alu_Status),
        .i_Id_Valid      (i_Id_Valid),
        .i_Id_S          (i_Id_S),
        .i_Id_Uses_Flags (i_Id_Uses_Flags),
        .i_Save          (i_Save),
        .i_Restore       (i_Restore),
        .o_Status        (o_Status),
        .o_Saved_Status  (o_Saved_Status),
        .o_Flag_Hazard   (o_Flag_Hazard)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic commit(input logic [3:0] flags);
        i_Ex_Valid = 1'b1; i_Ex_S = 1'b1; i_Ex_Cond_Pass = 1'b1; i_Alu_Status = flags;
        tick();
        i_Ex_Valid = 1'b0; i_Ex_S = 1'b0;
    endtask

    task automatic issue_writer();
        i_Id_Valid = 1'b1; i_Id_S = 1'b1; i_Id_Uses_Flags = 1'b0;
        tick();
        i_Id_S = 1'b0; i_Id_Uses_Flags = 1'b1;
        #1;
    endtask

    initial begin
        i_Reset_n = 1'b0;
        i_Stall = 0; i_Flush = 0;
        i_Ex_Valid = 0; i_Ex_S = 0; i_Ex_Cond_Pass = 0; i_Alu_Status = 4'b0000;
        i_Id_Valid = 0; i_Id_S = 0; i_Id_Uses_Flags = 0;
        i_Save = 0; i_Restore = 0;
        #12;
        check("reset_status", o_Status, 4'b0000);
        check("reset_saved", o_Saved_Status, 4'b0000);
        check("reset_hazard", {3'b0, o_Flag_Hazard}, 4'b0000);
        i_Reset_n = 1'b1;

        // Basic commit
        commit(4'b1010);
        check("commit_status", o_Status, 4'b1010);
        check("commit_saved", o_Saved_Status, 4'b0000);

        // Blocked commits
        i_Ex_Valid = 1; i_Ex_S = 1; i_Ex_Cond_Pass = 0; i_Alu_Status = 4'b0110;
        tick();
        check("cond_fail", o_Status, 4'b1010);
        i_Ex_Cond_Pass = 1; i_Flush = 1;
        tick();
        check("flush_block", o_Status, 4'b1010);
        i_Flush = 0; i_Stall = 1;
        tick();
        check("stall_block", o_Status, 4'b1010);
        i_Stall = 0; i_Ex_Valid = 0; i_Ex_S = 0;

        // Hazard: exactly two cycles
        issue_writer();
        check("haz_a1", {3'b0, o_Flag_Hazard}, 4'b0001);
        tick();
        check("haz_a2", {3'b0, o_Flag_Hazard}, 4'b0001);
        tick();
        check("haz_a3", {3'b0, o_Flag_Hazard}, 4'b0000);

        // Hazard stretched by a 3-cycle stall: five cycles total
        issue_writer();
        check("haz_b1", {3'b0, o_Flag_Hazard}, 4'b0001);
        i_Stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("haz_b_stall", {3'b0, o_Flag_Hazard}, 4'b0001);
        end
        i_Stall = 0;
        tick();
        check("haz_b5", {3'b0, o_Flag_Hazard}, 4'b0001);
        tick();
        check("haz_b6", {3'b0, o_Flag_Hazard}, 4'b0000);

        // Hazard cleared by flush
        issue_writer();
        check("haz_c1", {3'b0, o_Flag_Hazard}, 4'b0001);
        i_Flush = 1;
        tick();
        i_Flush = 0;
        #1;
        check("haz_c_flush", {3'b0, o_Flag_Hazard}, 4'b0000);
        i_Id_Valid = 0; i_Id_Uses_Flags = 0;

        // Save with same-cycle update, then restore
        commit(4'b0100);
        check("pre_save", o_Status, 4'b0100);
        i_Save = 1;
        commit(4'b1001);
        i_Save = 0;
        check("save_status", o_Status, 4'b1001);
        check("save_saved", o_Saved_Status, 4'b1001);
        commit(4'b0000);
        check("clear_status", o_Status, 4'b0000);
        i_Restore = 1;
        tick();
        i_Restore = 0;
        check("restore", o_Status, 4'b1001);

        // Save and restore together with an update pending
        commit(4'b0011);
        i_Save = 1; i_Restore = 1;
        commit(4'b1111);
        i_Save = 0; i_Restore = 0;
        check("sr_status", o_Status, 4'b1001);
        check("sr_saved", o_Saved_Status, 4'b1001);

        // Restore blocked by stall, not by flush
        commit(4'b0110);
        i_Restore = 1; i_Stall = 1;
        tick();
        check("restore_stall", o_Status, 4'b0110);
        i_Stall = 0; i_Flush = 1;
        tick();
        check("restore_flush", o_Status, 4'b1001);
        i_Restore = 0; i_Flush = 0;

        // Asynchronous reset mid-operation
        commit(4'b1100);
        issue_writer();
        check("pre_rst_hazard", {3'b0, o_Flag_Hazard}, 4'b0001);
        #2;
        i_Reset_n = 1'b0;
        #1;
        check("arst_status", o_Status, 4'b0000);
        check("arst_saved", o_Saved_Status, 4'b0000);
        check("arst_hazard", {3'b0, o_Flag_Hazard}, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
